// File: rtl/candy_sram_arbiter_pkg.sv
// Shared widths and FSM state encoding for the candy SRAM arbiter.
package candy_sram_arbiter_pkg;

    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_RD_ISSUE = 2'd1,
        ARB_RD_WAIT  = 2'd2,
        ARB_WR       = 2'd3
    } arb_state_t;

endpackage

// File: rtl/candy_rr_arb2.sv
// Two-way round-robin picker: bit 0 = instruction fetch, bit 1 = data memory.
module candy_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_win
);

    // High when dm held the most recent grant; cleared on reset so dm wins the first tie
    logic r_last_dm;

    // One-hot winner: a lone requester wins, a tie goes to the port not granted last
    always_comb begin
        o_win = 2'b00;
        case (i_req)
            2'b01:   o_win = 2'b01;
            2'b10:   o_win = 2'b10;
            2'b11:   o_win = r_last_dm ? 2'b01 : 2'b10;
            default: o_win = 2'b00;
        endcase
    end

    // Pointer register, moved only when a grant is actually taken
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_dm <= 1'b0;
        end else if (i_advance && (o_win != 2'b00)) begin
            r_last_dm <= o_win[1];
        end else begin
            r_last_dm <= r_last_dm;
        end
    end

endmodule

// File: rtl/candy_sram_arbiter.sv
// Arbitrates fetch and data-memory requests onto the shared candy SRAM,
// sequencing read issue/wait, writes, and read-timeout reporting.
module candy_sram_arbiter
    import candy_sram_arbiter_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_if_req,
    input  logic [SRAM_ADDR_W-1:0] i_if_addr,
    output logic                   o_if_gnt,
    output logic                   o_if_rvalid,
    output logic [SRAM_DATA_W-1:0] o_if_rdata,
    output logic                   o_if_err,
    input  logic                   i_dm_req,
    input  logic                   i_dm_we,
    input  logic [SRAM_ADDR_W-1:0] i_dm_addr,
    input  logic [SRAM_DATA_W-1:0] i_dm_wdata,
    output logic                   o_dm_gnt,
    output logic                   o_dm_rvalid,
    output logic [SRAM_DATA_W-1:0] o_dm_rdata,
    output logic                   o_dm_err,
    output logic                   o_sram_we,
    output logic                   o_sram_re,
    output logic [SRAM_ADDR_W-1:0] o_sram_waddr,
    output logic [SRAM_DATA_W-1:0] o_sram_wdata,
    output logic [SRAM_ADDR_W-1:0] o_sram_raddr,
    input  logic [SRAM_DATA_W-1:0] i_sram_rdata,
    input  logic                   i_sram_rdata_ready,
    output logic                   o_busy
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    // The counter is incremented on the timeout edge too, so it lands on WAIT_MAX
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_is_dm;
    logic [1:0]             w_win;
    logic                   w_idle;
    logic                   w_take;
    logic                   w_sel_dm;
    logic                   w_sel_we;
    logic [SRAM_ADDR_W-1:0] w_sel_addr;
    logic                   w_done;
    logic                   w_timeout;
    logic                   w_finish;
    logic [SRAM_DATA_W-1:0] w_ret_data;

    assign w_idle     = (r_state == ARB_IDLE);
    assign w_sel_dm   = w_win[1];
    assign w_sel_we   = w_sel_dm & i_dm_we;
    assign w_sel_addr = w_sel_dm ? i_dm_addr : i_if_addr;
    assign w_finish   = w_done | w_timeout;
    assign w_ret_data = w_done ? i_sram_rdata : '0;

    candy_rr_arb2 u_rr_arb2 (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     ({i_dm_req, i_if_req}),
        .i_advance (w_idle),
        .o_win     (w_win)
    );

    // Next-state logic; ready pulses outside RD_WAIT fall through unused
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_win != 2'b00) begin
                    w_take       = 1'b1;
                    w_next_state = w_sel_we ? ARB_WR : ARB_RD_ISSUE;
                end else begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_RD_ISSUE: w_next_state = ARB_RD_WAIT;
            ARB_RD_WAIT: begin
                if (i_sram_rdata_ready) begin
                    w_done       = 1'b1;
                    w_next_state = ARB_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = ARB_IDLE;
                end else begin
                    w_next_state = ARB_RD_WAIT;
                end
            end
            ARB_WR:  w_next_state = ARB_IDLE;
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // State, wait counter and committed-winner register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
            r_is_dm <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_take) begin
                r_is_dm <= w_sel_dm;
            end else begin
                r_is_dm <= r_is_dm;
            end
            case (r_state)
                ARB_RD_ISSUE: r_cnt <= '0;
                ARB_RD_WAIT:  r_cnt <= r_cnt + CNT_W'(1);
                default:      r_cnt <= r_cnt;
            endcase
        end
    end

    // Outputs are registered from the upcoming state so they line up with it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_if_gnt     <= 1'b0;
            o_dm_gnt     <= 1'b0;
            o_sram_re    <= 1'b0;
            o_sram_we    <= 1'b0;
            o_sram_raddr <= '0;
            o_sram_waddr <= '0;
            o_sram_wdata <= '0;
            o_if_rvalid  <= 1'b0;
            o_dm_rvalid  <= 1'b0;
            o_if_err     <= 1'b0;
            o_dm_err     <= 1'b0;
            o_if_rdata   <= '0;
            o_dm_rdata   <= '0;
            o_busy       <= 1'b0;
        end else begin
            o_if_gnt     <= w_take & ~w_sel_dm;
            o_dm_gnt     <= w_take & w_sel_dm;
            o_sram_re    <= w_take;
            o_sram_we    <= w_take & w_sel_we;
            o_sram_raddr <= (w_take & ~w_sel_we) ? w_sel_addr : '0;
            o_sram_waddr <= (w_take & w_sel_we) ? w_sel_addr : '0;
            o_sram_wdata <= (w_take & w_sel_we) ? i_dm_wdata : '0;
            o_if_rvalid  <= w_finish & ~r_is_dm;
            o_dm_rvalid  <= w_finish & r_is_dm;
            o_if_err     <= w_timeout & ~r_is_dm;
            o_dm_err     <= w_timeout & r_is_dm;
            if (w_finish & ~r_is_dm) begin
                o_if_rdata <= w_ret_data;
            end else begin
                o_if_rdata <= o_if_rdata;
            end
            if (w_finish & r_is_dm) begin
                o_dm_rdata <= w_ret_data;
            end else begin
                o_dm_rdata <= o_dm_rdata;
            end
            o_busy <= (w_next_state != ARB_IDLE);
        end
    end

endmodule

// File: tb/tb_candy_sram_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level schedule model.
module tb_candy_sram_arbiter;
    import candy_sram_arbiter_pkg::*;

    localparam int AW   = SRAM_ADDR_W;
    localparam int DW   = SRAM_DATA_W;
    localparam int WMAX = 15;
    localparam int NRUN = 800;
    localparam int NARR = NRUN + 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_if_req, i_dm_req, i_dm_we, i_sram_rdata_ready;
    logic [AW-1:0] i_if_addr, i_dm_addr;
    logic [DW-1:0] i_dm_wdata, i_sram_rdata;
    logic          o_if_gnt, o_if_rvalid, o_if_err, o_dm_gnt, o_dm_rvalid, o_dm_err;
    logic          o_sram_we, o_sram_re, o_busy;
    logic [DW-1:0] o_if_rdata, o_dm_rdata, o_sram_wdata;
    logic [AW-1:0] o_sram_waddr, o_sram_raddr;
    logic [8:0]    flags;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-cycle schedule for the randomized run
    logic          e_if_gnt [NARR];
    logic          e_dm_gnt [NARR];
    logic          e_if_rv  [NARR];
    logic          e_dm_rv  [NARR];
    logic          e_err    [NARR];
    logic [DW-1:0] e_rdat   [NARR];
    logic          e_we     [NARR];
    logic          e_re     [NARR];
    logic [AW-1:0] e_raddr  [NARR];
    logic [AW-1:0] e_waddr  [NARR];
    logic [DW-1:0] e_wdata  [NARR];
    logic          e_busy   [NARR];
    logic          rdy      [NARR];
    logic [DW-1:0] rdy_dat  [NARR];
    logic          in_wait  [NARR];
    logic [DW-1:0] mem      [64];

    always #5 clk = ~clk;

    assign flags = {o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_if_err, o_dm_err,
                    o_sram_we, o_sram_re, o_busy};

    candy_sram_arbiter #(.WAIT_MAX(WMAX)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_if_req           (i_if_req),
        .i_if_addr          (i_if_addr),
        .o_if_gnt           (o_if_gnt),
        .o_if_rvalid        (o_if_rvalid),
        .o_if_rdata         (o_if_rdata),
        .o_if_err           (o_if_err),
        .i_dm_req           (i_dm_req),
        .i_dm_we            (i_dm_we),
        .i_dm_addr          (i_dm_addr),
        .i_dm_wdata         (i_dm_wdata),
        .o_dm_gnt           (o_dm_gnt),
        .o_dm_rvalid        (o_dm_rvalid),
        .o_dm_rdata         (o_dm_rdata),
        .o_dm_err           (o_dm_err),
        .o_sram_we          (o_sram_we),
        .o_sram_re          (o_sram_re),
        .o_sram_waddr       (o_sram_waddr),
        .o_sram_wdata       (o_sram_wdata),
        .o_sram_raddr       (o_sram_raddr),
        .i_sram_rdata       (i_sram_rdata),
        .i_sram_rdata_ready (i_sram_rdata_ready),
        .o_busy             (o_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_if_req = 1'b0; i_if_addr = '0;
        i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_addr = '0; i_dm_wdata = '0;
        i_sram_rdata_ready = 1'b0; i_sram_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (flags !== 9'd0) begin
            n_bad++; $display("FAIL reset_flags: got %b want %b", flags, 9'd0);
        end
        n_cmp++;
        if ({o_if_rdata, o_dm_rdata} !== 64'd0) begin
            n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", o_if_rdata, o_dm_rdata);
        end
        n_cmp++;
        if ({o_sram_raddr, o_sram_waddr, o_sram_wdata} !== 64'd0) begin
            n_bad++; $display("FAIL reset_sram_bus: got %h %h %h want 0", o_sram_raddr, o_sram_waddr, o_sram_wdata);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (flags !== 9'd0) begin
            n_bad++; $display("FAIL reset_idle: got %b want %b", flags, 9'd0);
        end
    endtask

    task automatic test_single_read();
        idle_inputs();
        i_if_req = 1'b1; i_if_addr = 16'h0010;
        tick();
        i_if_req = 1'b0;
        n_cmp++;
        if (flags !== 9'b100000011) begin
            n_bad++; $display("FAIL read_issue_flags: got %b want %b", flags, 9'b100000011);
        end
        n_cmp++;
        if (o_sram_raddr !== 16'h0010) begin
            n_bad++; $display("FAIL read_raddr: got %h want %h", o_sram_raddr, 16'h0010);
        end
        tick();
        n_cmp++;
        if (flags !== 9'b000000001) begin
            n_bad++; $display("FAIL read_wait_flags: got %b want %b", flags, 9'b000000001);
        end
        i_sram_rdata_ready = 1'b1; i_sram_rdata = 32'hDEAD_BEEF;
        tick();
        i_sram_rdata_ready = 1'b0; i_sram_rdata = 32'h0BAD_F00D;
        n_cmp++;
        if (flags !== 9'b001000000) begin
            n_bad++; $display("FAIL read_return_flags: got %b want %b", flags, 9'b001000000);
        end
        n_cmp++;
        if (o_if_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL read_data: got %h want %h", o_if_rdata, 32'hDEAD_BEEF);
        end
        tick();
        n_cmp++;
        if (o_if_rvalid !== 1'b0 || o_if_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL read_hold: got rv=%b %h want rv=0 %h", o_if_rvalid, o_if_rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_write();
        idle_inputs();
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 16'h0020; i_dm_wdata = 32'h0000_1234;
        tick();
        i_dm_req = 1'b0;
        n_cmp++;
        if (flags !== 9'b010000111) begin
            n_bad++; $display("FAIL write_flags: got %b want %b", flags, 9'b010000111);
        end
        n_cmp++;
        if (o_sram_waddr !== 16'h0020 || o_sram_wdata !== 32'h0000_1234 || o_sram_raddr !== 16'h0000) begin
            n_bad++; $display("FAIL write_bus: got %h %h %h want 0020 00001234 0000", o_sram_waddr, o_sram_wdata, o_sram_raddr);
        end
        tick();
        n_cmp++;
        if (flags !== 9'd0) begin
            n_bad++; $display("FAIL write_done: got %b want %b", flags, 9'd0);
        end
        tick();
        n_cmp++;
        if (o_dm_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL write_no_rvalid: got %b want 0", o_dm_rvalid);
        end
    endtask

    task automatic test_conflict();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_if_req = 1'b1; i_if_addr = 16'h0100;
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            logic          exp_dm;
            logic [AW-1:0] ea;
            logic [DW-1:0] got;
            exp_dm = (k % 2 == 0);
            ea     = exp_dm ? 16'h0200 : 16'h0100;
            tick();
            n_cmp++;
            if ({o_if_gnt, o_dm_gnt} !== {~exp_dm, exp_dm} || o_sram_raddr !== ea) begin
                n_bad++; $display("FAIL conflict_gnt[%0d]: got if=%b dm=%b addr=%h want if=%b dm=%b addr=%h",
                                  k, o_if_gnt, o_dm_gnt, o_sram_raddr, ~exp_dm, exp_dm, ea);
            end
            tick();
            i_sram_rdata_ready = 1'b1; i_sram_rdata = {16'hC0DE, ea};
            tick();
            i_sram_rdata_ready = 1'b0;
            got = exp_dm ? o_dm_rdata : o_if_rdata;
            n_cmp++;
            if ({o_if_rvalid, o_dm_rvalid} !== {~exp_dm, exp_dm} || got !== {16'hC0DE, ea}) begin
                n_bad++; $display("FAIL conflict_rv[%0d]: got if=%b dm=%b data=%h want if=%b dm=%b data=%h",
                                  k, o_if_rvalid, o_dm_rvalid, got, ~exp_dm, exp_dm, {16'hC0DE, ea});
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        idle_inputs();
        i_if_req = 1'b1; i_if_addr = 16'h0033;
        tick();
        i_if_req = 1'b0;
        n_cmp++;
        if (o_if_gnt !== 1'b1) begin
            n_bad++; $display("FAIL timeout_gnt: got %b want 1", o_if_gnt);
        end
        for (int k = 1; k <= WMAX; k++) begin
            tick();
            n_cmp++;
            if (o_if_rvalid !== 1'b0 || o_if_err !== 1'b0 || o_busy !== 1'b1) begin
                n_bad++; $display("FAIL timeout_early[%0d]: got rv=%b err=%b busy=%b want 0 0 1", k, o_if_rvalid, o_if_err, o_busy);
            end
        end
        tick();
        n_cmp++;
        if ({o_if_rvalid, o_if_err, o_busy} !== 3'b110 || o_if_rdata !== 32'd0) begin
            n_bad++; $display("FAIL timeout_err: got rv=%b err=%b busy=%b data=%h want 1 1 0 0",
                              o_if_rvalid, o_if_err, o_busy, o_if_rdata);
        end
        tick();
        n_cmp++;
        if (flags !== 9'd0) begin
            n_bad++; $display("FAIL timeout_idle: got %b want %b", flags, 9'd0);
        end
    endtask

    task automatic test_reset_mid_read();
        idle_inputs();
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 16'h0044;
        tick();
        i_dm_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_sram_rdata_ready = 1'b1; i_sram_rdata = 32'h5555_AAAA;
        n_cmp++;
        if (flags !== 9'd0 || {o_if_rdata, o_dm_rdata, o_sram_raddr} !== 80'd0) begin
            n_bad++; $display("FAIL midrst_outputs: got %b %h %h %h want all 0", flags, o_if_rdata, o_dm_rdata, o_sram_raddr);
        end
        tick();
        i_sram_rdata_ready = 1'b0;
        n_cmp++;
        if (flags !== 9'd0 || o_dm_rdata !== 32'd0) begin
            n_bad++; $display("FAIL midrst_late_ready: got %b %h want 0 0", flags, o_dm_rdata);
        end
        i_if_req = 1'b1; i_if_addr = 16'h0101;
        i_dm_req = 1'b1; i_dm_addr = 16'h0202;
        tick();
        n_cmp++;
        if ({o_if_gnt, o_dm_gnt} !== 2'b01) begin
            n_bad++; $display("FAIL midrst_ptr: got if=%b dm=%b want if=0 dm=1", o_if_gnt, o_dm_gnt);
        end
        idle_inputs();
        tick();
        i_sram_rdata_ready = 1'b1; i_sram_rdata = 32'h0000_0001;
        tick();
        i_sram_rdata_ready = 1'b0;
        n_cmp++;
        if ({o_if_rvalid, o_dm_rvalid} !== 2'b01) begin
            n_bad++; $display("FAIL midrst_return: got if=%b dm=%b want 0 1", o_if_rvalid, o_dm_rvalid);
        end
        tick();
    endtask

    task automatic test_stray_ready();
        idle_inputs();
        i_sram_rdata_ready = 1'b1; i_sram_rdata = 32'hFFFF_0000;
        tick();
        i_sram_rdata_ready = 1'b0;
        n_cmp++;
        if (flags !== 9'd0) begin
            n_bad++; $display("FAIL stray_flags: got %b want %b", flags, 9'd0);
        end
        tick();
        n_cmp++;
        if (o_busy !== 1'b0 || o_if_rvalid !== 1'b0 || o_dm_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL stray_idle: got busy=%b rv=%b%b want 0 00", o_busy, o_if_rvalid, o_dm_rvalid);
        end
    endtask

    task automatic test_random();
        logic          if_pend, dm_pend, dm_wr, last_dm, win_dm, tk;
        logic [AW-1:0] if_a, dm_a, a;
        logic [DW-1:0] dm_d, x_if_rdata, x_dm_rdata;
        logic [8:0]    xf;
        int            t_free, d, done;
        for (int i = 0; i < NARR; i++) begin
            e_if_gnt[i] = 1'b0; e_dm_gnt[i] = 1'b0; e_if_rv[i] = 1'b0; e_dm_rv[i] = 1'b0;
            e_err[i] = 1'b0; e_rdat[i] = '0; e_we[i] = 1'b0; e_re[i] = 1'b0;
            e_raddr[i] = '0; e_waddr[i] = '0; e_wdata[i] = '0; e_busy[i] = 1'b0;
            rdy[i] = 1'b0; rdy_dat[i] = '0; in_wait[i] = 1'b0;
        end
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_pend = 1'b0; dm_pend = 1'b0; dm_wr = 1'b0; last_dm = 1'b0; t_free = 0;
        if_a = '0; dm_a = '0; dm_d = '0; x_if_rdata = '0; x_dm_rdata = '0;
        for (int t = 0; t < NRUN; t++) begin
            if (e_if_rv[t]) x_if_rdata = e_rdat[t];
            if (e_dm_rv[t]) x_dm_rdata = e_rdat[t];
            xf = {e_if_gnt[t], e_dm_gnt[t], e_if_rv[t], e_dm_rv[t], e_if_rv[t] & e_err[t],
                  e_dm_rv[t] & e_err[t], e_we[t], e_re[t], e_busy[t]};
            n_cmp++;
            if (flags !== xf) begin
                n_bad++; $display("FAIL rnd_flags t=%0d: got %b want %b", t, flags, xf);
            end
            n_cmp++;
            if ({o_sram_raddr, o_sram_waddr, o_sram_wdata} !== {e_raddr[t], e_waddr[t], e_wdata[t]}) begin
                n_bad++; $display("FAIL rnd_bus t=%0d: got %h %h %h want %h %h %h", t, o_sram_raddr, o_sram_waddr,
                                  o_sram_wdata, e_raddr[t], e_waddr[t], e_wdata[t]);
            end
            n_cmp++;
            if (o_if_rdata !== x_if_rdata || o_dm_rdata !== x_dm_rdata) begin
                n_bad++; $display("FAIL rnd_rdata t=%0d: got %h %h want %h %h", t, o_if_rdata, o_dm_rdata, x_if_rdata, x_dm_rdata);
            end
            if (!if_pend && t < NRUN - 60 && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1; if_a = AW'($urandom_range(0, 63));
            end
            if (!dm_pend && t < NRUN - 60 && $urandom_range(0, 2) == 0) begin
                dm_pend = 1'b1; dm_a = AW'($urandom_range(0, 63));
                dm_wr = 1'($urandom_range(0, 1)); dm_d = $urandom;
            end
            tk = 1'b0; win_dm = 1'b0;
            if (t >= t_free && (if_pend || dm_pend)) begin
                tk      = 1'b1;
                win_dm  = (if_pend && dm_pend) ? !last_dm : dm_pend;
                last_dm = win_dm;
                e_busy[t+1] = 1'b1; e_re[t+1] = 1'b1;
                if (win_dm) e_dm_gnt[t+1] = 1'b1; else e_if_gnt[t+1] = 1'b1;
                if (win_dm && dm_wr) begin
                    e_we[t+1] = 1'b1; e_waddr[t+1] = dm_a; e_wdata[t+1] = dm_d;
                    mem[dm_a[5:0]] = dm_d;
                    t_free = t + 2;
                end else begin
                    a = win_dm ? dm_a : if_a;
                    e_raddr[t+1] = a;
                    d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, WMAX));
                    if (d > 0) begin
                        rdy[t+1+d] = 1'b1; rdy_dat[t+1+d] = mem[a[5:0]];
                        done = t + 2 + d;
                        e_rdat[done] = mem[a[5:0]];
                    end else begin
                        done = t + 2 + WMAX;
                        e_rdat[done] = '0;
                        e_err[done] = 1'b1;
                    end
                    if (win_dm) e_dm_rv[done] = 1'b1; else e_if_rv[done] = 1'b1;
                    for (int k = t + 2; k < done; k++) begin
                        e_busy[k] = 1'b1; in_wait[k] = 1'b1;
                    end
                    t_free = done;
                end
            end
            if (!rdy[t] && !in_wait[t] && $urandom_range(0, 7) == 0) begin
                rdy[t] = 1'b1; rdy_dat[t] = $urandom;
            end
            i_if_req = if_pend; i_if_addr = if_a;
            i_dm_req = dm_pend; i_dm_we = dm_wr; i_dm_addr = dm_a; i_dm_wdata = dm_d;
            i_sram_rdata_ready = rdy[t];
            i_sram_rdata = rdy[t] ? rdy_dat[t] : DW'($urandom);
            if (tk) begin
                if (win_dm) dm_pend = 1'b0; else if_pend = 1'b0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write();
        test_conflict();
        test_timeout();
        test_reset_mid_read();
        test_stray_ready();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
